// File: rtl/ipl_loader_if.sv
// Avalon-MM write bus from the IPL loader into the on-chip boot memory.
`timescale 1ns/1ps
interface ipl_loader_if;
  logic [10:0] avm_address;
  logic [3:0]  avm_byteenable;
  logic        avm_chipselect;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic        avm_clken;

  modport master (
    output avm_address, avm_byteenable, avm_chipselect, avm_write,
           avm_writedata, avm_clken
  );

  modport slave (
    input  avm_address, avm_byteenable, avm_chipselect, avm_write,
           avm_writedata, avm_clken
  );
endinterface

// File: rtl/ipl_loader.sv
// Copies a boot image from SPI flash (mode 0, READ 0x03) into IPL memory, holding the CPU in reset.
// Define IPL_LOADER_CHECKSUM_EN to read a trailing sum word and verify the image against it.
`timescale 1ns/1ps
module ipl_loader #(
  parameter logic [23:0] FLASH_OFFSET = 24'h000000,
  parameter int unsigned WORD_COUNT   = 2048,
  parameter int unsigned SCLK_DIV     = 2,
  parameter bit          AUTOSTART    = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  output logic         spi_ss_n,
  output logic         spi_sck,
  output logic         spi_mosi,
  input  logic         spi_miso,
  ipl_loader_if.master avm,
  output logic         cpu_reset_req,
  output logic         busy,
  output logic         done,
  output logic         error
);

  localparam int unsigned      DIV_W    = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
  localparam logic [10:0]      LAST_IDX = 11'(WORD_COUNT - 1);
  localparam logic [31:0]      READ_CMD = {8'h03, FLASH_OFFSET};

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_READ, ST_WRITE, ST_CHECK, ST_DONE, ST_FAIL
  } state_e;

  state_e            state_q, state_d;
  logic              auto_q, auto_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [4:0]        bit_q, bit_d;
  logic [31:0]       tx_q, tx_d;
  logic [31:0]       rx_q, rx_d;
  logic              ss_n_q, ss_n_d;
  logic              sck_q, sck_d;
  logic [10:0]       idx_q, idx_d;
  logic [31:0]       wdata_q, wdata_d;
`ifdef IPL_LOADER_CHECKSUM_EN
  logic [31:0]       sum_q, sum_d;
  logic              trailer_q, trailer_d;
`endif

  logic launch, tick, fall, word_end, last_word;

  // Flash sends the first byte first; it lands in the least significant lane.
  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  always_comb begin
    state_d   = state_q;
    auto_d    = auto_q;
    div_d     = div_q;
    bit_d     = bit_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    ss_n_d    = ss_n_q;
    sck_d     = sck_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
`ifdef IPL_LOADER_CHECKSUM_EN
    sum_d     = sum_q;
    trailer_d = trailer_q;
`endif
    launch    = 1'b0;
    tick      = (div_q == DIV_LAST);
    fall      = tick & sck_q;
    word_end  = fall & (bit_q == 5'd31);
    last_word = (idx_q == LAST_IDX);

    case (state_q)
      ST_IDLE: launch = start | auto_q;

      ST_CMD, ST_READ: begin
        div_d = tick ? '0 : div_q + 1'b1;
        if (tick)
          sck_d = ~sck_q;
        if (tick & ~sck_q)
          rx_d = {rx_q[30:0], spi_miso};
        // MOSI is tx_q[31]; the shifter empties to zero, so MOSI idles low in READ.
        if (fall) begin
          bit_d = bit_q + 5'd1;
          tx_d  = {tx_q[30:0], 1'b0};
        end
        if (word_end) begin
          if (state_q == ST_CMD) begin
            state_d = ST_READ;
          end else begin
`ifdef IPL_LOADER_CHECKSUM_EN
            if (trailer_q) begin
              state_d = ST_CHECK;
              ss_n_d  = 1'b1;
            end else begin
              state_d = ST_WRITE;
              wdata_d = byte_swap(rx_q);
            end
`else
            state_d = ST_WRITE;
            wdata_d = byte_swap(rx_q);
            ss_n_d  = last_word;
`endif
          end
        end
      end

      ST_WRITE: begin
`ifdef IPL_LOADER_CHECKSUM_EN
        sum_d = sum_q + wdata_q;
`endif
        // The index holds on the last word rather than wrapping to 0.
        if (last_word) begin
`ifdef IPL_LOADER_CHECKSUM_EN
          trailer_d = 1'b1;
          state_d   = ST_READ;
`else
          state_d   = ST_CHECK;
`endif
        end else begin
          idx_d   = idx_q + 11'd1;
          state_d = ST_READ;
        end
      end

      ST_CHECK: begin
`ifdef IPL_LOADER_CHECKSUM_EN
        state_d = (byte_swap(rx_q) == sum_q) ? ST_DONE : ST_FAIL;
`else
        state_d = ST_DONE;
`endif
      end

      ST_DONE, ST_FAIL: launch = start;

      default: state_d = ST_IDLE;
    endcase

    if (launch) begin
      state_d   = ST_CMD;
      auto_d    = 1'b0;
      ss_n_d    = 1'b0;
      sck_d     = 1'b0;
      div_d     = '0;
      bit_d     = '0;
      tx_d      = READ_CMD;
      idx_d     = '0;
`ifdef IPL_LOADER_CHECKSUM_EN
      sum_d     = '0;
      trailer_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      auto_q    <= AUTOSTART;
      div_q     <= '0;
      bit_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      ss_n_q    <= 1'b1;
      sck_q     <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
`ifdef IPL_LOADER_CHECKSUM_EN
      sum_q     <= '0;
      trailer_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      auto_q    <= auto_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      ss_n_q    <= ss_n_d;
      sck_q     <= sck_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
`ifdef IPL_LOADER_CHECKSUM_EN
      sum_q     <= sum_d;
      trailer_q <= trailer_d;
`endif
    end
  end

  assign spi_ss_n = ss_n_q;
  assign spi_sck  = sck_q;
  assign spi_mosi = tx_q[31];

  assign avm.avm_address    = idx_q;
  assign avm.avm_byteenable = (state_q == ST_WRITE) ? 4'hF : 4'h0;
  assign avm.avm_chipselect = (state_q == ST_WRITE);
  assign avm.avm_write      = (state_q == ST_WRITE);
  assign avm.avm_writedata  = wdata_q;
  assign avm.avm_clken      = 1'b1;

  assign busy          = (state_q == ST_CMD) || (state_q == ST_READ) ||
                         (state_q == ST_WRITE) || (state_q == ST_CHECK);
  assign done          = (state_q == ST_DONE);
  assign cpu_reset_req = (state_q != ST_DONE);
`ifdef IPL_LOADER_CHECKSUM_EN
  assign error         = (state_q == ST_FAIL);
`else
  assign error         = 1'b0;
`endif

endmodule

// File: tb/tb_ipl_loader.sv
// Bench for ipl_loader: behavioural SPI flash, write scoreboard, restart/abort scenarios.
`timescale 1ns/1ps
module tb_ipl_loader;

  localparam logic [23:0] OFFSET = 24'h000020;
  localparam int          WC     = 4;
  localparam int          DIV    = 3;
`ifdef IPL_LOADER_CHECKSUM_EN
  localparam int          CK     = 1;
`else
  localparam int          CK     = 0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic ss_n, sck, mosi;
  logic miso = 1'b0;
  logic cpu_reset_req, busy, done, error;

  ipl_loader_if bus ();

  ipl_loader #(
    .FLASH_OFFSET (OFFSET),
    .WORD_COUNT   (WC),
    .SCLK_DIV     (DIV),
    .AUTOSTART    (1'b1)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .spi_ss_n      (ss_n),
    .spi_sck       (sck),
    .spi_mosi      (mosi),
    .spi_miso      (miso),
    .avm           (bus),
    .cpu_reset_req (cpu_reset_req),
    .busy          (busy),
    .done          (done),
    .error         (error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- flash model ----------------
  logic [7:0]  flash [0:255];
  int unsigned cyc = 0;
  int unsigned nbits = 0;
  int unsigned t_edge = 0;
  logic [31:0] cmd_sr = '0;
  logic        prev_sck = 1'b0;
  logic        prev_ss = 1'b1;
  logic        aborting = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge sck or negedge sck or posedge ss_n or negedge ss_n) begin
    if (!ss_n && prev_ss) begin
      nbits  = 0;
      cmd_sr = '0;
      t_edge = cyc;
    end
    if (!ss_n && sck && !prev_sck) begin
      if (nbits < 32) begin
        chk("sck_low_phase", cyc - t_edge, DIV);
        cmd_sr = {cmd_sr[30:0], mosi};
      end
      nbits++;
      t_edge = cyc;
      if (nbits == 32) chk("spi_command", cmd_sr, {8'h03, OFFSET});
    end
    if (!sck && prev_sck && !aborting) begin
      logic [7:0]  byte_v;
      int unsigned k;
      chk("sck_high_phase", cyc - t_edge, DIV);
      t_edge = cyc;
      if (nbits >= 32) begin
        k      = nbits - 32;
        byte_v = flash[(int'(OFFSET) + k / 8) & 255];
        miso   = byte_v[7 - (k % 8)];
      end
    end
    if (ss_n && !prev_ss && !aborting)
      chk("ss_low_sck_periods", nbits, 32 * (WC + 1 + CK));
    prev_sck = sck;
    prev_ss  = ss_n;
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct packed {
    logic [10:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t  exp_q[$];
  logic exp_fail = 1'b0;
  int   n_writes = 0;

  task automatic randomize_flash();
    for (int i = 0; i < 256; i++) flash[i] = 8'($urandom);
  endtask

  // Image words are little-endian byte groups at OFFSET; trailer follows the image.
  task automatic push_load(input bit bad);
    logic [31:0] sum, w, t;
    int a;
    sum = '0;
    for (int i = 0; i < WC; i++) begin
      a = int'(OFFSET) + 4 * i;
      w = {flash[a + 3], flash[a + 2], flash[a + 1], flash[a]};
      exp_q.push_back('{addr: 11'(i), data: w});
      sum += w;
    end
    t = bad ? sum + 32'd1 : sum;
    a = int'(OFFSET) + 4 * WC;
    flash[a] = t[7:0]; flash[a + 1] = t[15:8]; flash[a + 2] = t[23:16]; flash[a + 3] = t[31:24];
    exp_fail = bad && (CK == 1);
  endtask

  logic [31:0] last_wdata = '0;
  logic        wr_prev = 1'b0;

  always @(negedge clk) begin
    if (!reset_n) begin
      last_wdata = '0;
      wr_prev    = 1'b0;
    end else if (bus.avm_chipselect || bus.avm_write) begin
      n_writes++;
      chk("write_single_cycle", wr_prev, 0);
      chk("write_strobe_pair", {bus.avm_chipselect, bus.avm_write}, 2'b11);
      chk("write_byteenable", bus.avm_byteenable, 4'hF);
      if (exp_q.size() == 0) begin
        chk("write_expected", exp_q.size(), 1);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write_address", bus.avm_address, e.addr);
        chk("write_data", bus.avm_writedata, e.data);
        last_wdata = e.data;
      end
      wr_prev = 1'b1;
    end else begin
      wr_prev = 1'b0;
      chk("idle_byteenable", bus.avm_byteenable, 4'h0);
      chk("idle_writedata_hold", bus.avm_writedata, last_wdata);
    end
  end

  // ---------------- stimulus ----------------
  task automatic check_reset_outputs();
    chk("rst_ss_n", ss_n, 1);
    chk("rst_sck", sck, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_chipselect", bus.avm_chipselect, 0);
    chk("rst_write", bus.avm_write, 0);
    chk("rst_address", bus.avm_address, 0);
    chk("rst_byteenable", bus.avm_byteenable, 0);
    chk("rst_writedata", bus.avm_writedata, 0);
    chk("rst_clken", bus.avm_clken, 1);
    chk("rst_cpu_reset_req", cpu_reset_req, 1);
    chk("rst_status", {busy, done, error}, 3'b000);
  endtask

  task automatic wait_finish();
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      if (done || error) break;
    end
    chk("load_finished", done | error, 1);
    chk("end_done", done, !exp_fail);
    chk("end_error", error, exp_fail);
    chk("end_cpu_reset_req", cpu_reset_req, exp_fail);
    chk("end_busy", busy, 0);
    chk("end_pending_writes", exp_q.size(), 0);
  endtask

  task automatic wait_writes(input int target);
    for (int i = 0; i < 4000; i++) begin
      if (n_writes >= target) break;
      @(negedge clk);
    end
    chk("writes_reached", n_writes >= target, 1);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int base;
    randomize_flash();
    repeat (3) @(posedge clk);
    #1 check_reset_outputs();

    // Load 1: autostart right after reset release.
    @(negedge clk);
    push_load(1'b0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("auto_busy", busy, 1);
    chk("auto_ss_low", ss_n, 0);
    chk("auto_cpu_reset_req", cpu_reset_req, 1);
    wait_finish();

    // Load 2: start from DONE, extra start during READ must be ignored.
    randomize_flash();
    push_load(1'b1);
    base = n_writes;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("restart_cpu_reset_req", cpu_reset_req, 1);
    chk("restart_busy", busy, 1);
    chk("restart_done", done, 0);
    wait_writes(base + 1);
    pulse_start();
    wait_finish();
    chk("write_count", n_writes - base, WC);

    // Load 3: aborted by reset after the second write, then autostart again.
    randomize_flash();
    push_load(1'b0);
    base = n_writes;
    pulse_start();
    wait_writes(base + 2);
    @(posedge clk);
    #2;
    aborting = 1'b1;
    reset_n  = 1'b0;
    #1 check_reset_outputs();
    exp_q.delete();
    repeat (2) @(negedge clk);
    chk("abort_no_writes", n_writes - base, 2);
    aborting = 1'b0;
    randomize_flash();
    push_load(1'b0);
    reset_n = 1'b1;
    wait_finish();

    chk("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
